// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: op codes, FSM states
// and small op classification helpers.
package alu_serial_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_XOR);
  endfunction

  // Only ADD/SUB use the carry chain and report carry/overflow.
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_serial_shreg.sv
// WIDTH-bit right-shifting register with parallel load; serial data enters at
// the MSB so an LSB-first stream assembles into a word.
module serial_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Load has priority over shift; otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= {WIDTH{1'b0}};
    end else if (load) begin
      q_r <= load_val;
    end else if (shift) begin
      q_r <= {sin, q_r[WIDTH-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Sequencer for the bit-serial ALU: feeds operand bits LSB first to an external
// 1-bit slice, collects the result and flags, and hands them to writeback.
module alu_serial_ctrl
  import alu_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_op,
  input  logic             slice_res,
  input  logic             slice_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_illegal
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_s;
  logic             accept_s, last_s, run_s;
  logic             req_ready_r, rsp_valid_r;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] count_r;
  logic             carry_r, acc_r;
  logic             rsp_zero_r, rsp_carry_r, rsp_ovf_r, rsp_illegal_r;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             unused_s;

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= (state_s == ST_IDLE);
      rsp_valid_r <= (state_s == ST_DONE);
    end
  end

  // Next-state logic and per-cycle strobes.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = op_is_legal(req_op) ? ST_RUN : ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count_r == LAST_CNT) begin
          last_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign run_s = (state_r == ST_RUN);

  // Op latch, bit counter, carry FF and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r          <= 3'd0;
      count_r       <= {CNT_W{1'b0}};
      carry_r       <= 1'b0;
      acc_r         <= 1'b0;
      rsp_zero_r    <= 1'b0;
      rsp_carry_r   <= 1'b0;
      rsp_ovf_r     <= 1'b0;
      rsp_illegal_r <= 1'b0;
    end else if (accept_s) begin
      op_r          <= req_op;
      count_r       <= {CNT_W{1'b0}};
      carry_r       <= (req_op == OP_SUB);
      acc_r         <= 1'b0;
      rsp_zero_r    <= 1'b0;
      rsp_carry_r   <= 1'b0;
      rsp_ovf_r     <= 1'b0;
      rsp_illegal_r <= ~op_is_legal(req_op);
    end else if (run_s) begin
      count_r <= count_r + CNT_ONE;
      acc_r   <= acc_r | slice_res;
      if (op_is_arith(op_r)) begin
        carry_r <= slice_cout;
      end
      // carry_r is the carry into the MSB on the final bit.
      if (last_s) begin
        rsp_zero_r  <= ~(acc_r | slice_res);
        rsp_carry_r <= op_is_arith(op_r) & slice_cout;
        rsp_ovf_r   <= op_is_arith(op_r) & (carry_r ^ slice_cout);
      end
    end
  end

  serial_shreg #(.WIDTH(WIDTH)) u_sr_a (
    .clk(clk), .rst(rst), .load(accept_s), .shift(run_s),
    .load_val(req_a), .sin(1'b0), .q(a_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_sr_b (
    .clk(clk), .rst(rst), .load(accept_s), .shift(run_s),
    .load_val(req_b), .sin(1'b0), .q(b_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_sr_res (
    .clk(clk), .rst(rst), .load(accept_s), .shift(run_s),
    .load_val({WIDTH{1'b0}}), .sin(slice_res), .q(res_q)
  );

  // Operand upper bits only matter as they shift down to bit 0.
  assign unused_s = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

  assign slice_a   = run_s & a_q[0];
  assign slice_b   = run_s & (b_q[0] ^ (op_r == OP_SUB));
  assign slice_cin = run_s & carry_r;
  assign slice_op  = run_s ? op_r : 3'd0;

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_result  = res_q;
  assign rsp_zero    = rsp_zero_r;
  assign rsp_carry   = rsp_carry_r;
  assign rsp_ovf     = rsp_ovf_r;
  assign rsp_illegal = rsp_illegal_r;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit ALU slice and op mux.
module tb_alu_serial_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a, req_b;
  logic             slice_a, slice_b, slice_cin;
  logic [2:0]       slice_op;
  logic             slice_res, slice_cout;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero, rsp_carry, rsp_ovf, rsp_illegal;

  int checks = 0;
  int errors = 0;

  alu_serial_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_op(slice_op),
    .slice_res(slice_res), .slice_cout(slice_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf),
    .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  // Real 1-bit slice: full adder for ADD/SUB (controller inverts B), logic ops otherwise.
  always_comb begin
    slice_res  = 1'b0;
    slice_cout = 1'b0;
    case (slice_op)
      3'd0: slice_res = slice_a & slice_b;
      3'd1: slice_res = slice_a | slice_b;
      3'd2, 3'd3: begin
        slice_res  = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
      end
      3'd4: slice_res = slice_a ^ slice_b;
      default: slice_res = 1'b0;
    endcase
  end

  // Present one request, then wait (bounded) for rsp_valid; lat = edges after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL issue_req_ready got %b want 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'd7; req_a = 16'hDEAD; req_b = 16'hBEEF;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL issue_timeout got rsp_valid=%b want 1 within 64 clocks", rsp_valid);
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, rsp_valid, rsp_zero, rsp_carry, rsp_ovf, rsp_illegal} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got rdy/vld/z/c/o/i=%b want 100000",
        {req_ready, rsp_valid, rsp_zero, rsp_carry, rsp_ovf, rsp_illegal});
    end
    checks++;
    if (rsp_result !== 16'h0000) begin
      errors++; $display("FAIL reset_result got %h want 0000", rsp_result);
    end
    checks++;
    if ({slice_a, slice_b, slice_cin, slice_op} !== 6'b000000) begin
      errors++; $display("FAIL reset_slice got %b want 000000", {slice_a, slice_b, slice_cin, slice_op});
    end
  endtask

  task automatic test_add();
    int lat;
    issue(3'd2, 16'h7FFF, 16'h0001, lat);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL add_latency got %0d want 16", lat); end
    checks++;
    if (rsp_result !== 16'h8000) begin errors++; $display("FAIL add_result got %h want 8000", rsp_result); end
    checks++;
    if ({rsp_zero, rsp_carry, rsp_ovf, rsp_illegal} !== 4'b0010) begin
      errors++; $display("FAIL add_flags got z/c/o/i=%b want 0010", {rsp_zero, rsp_carry, rsp_ovf, rsp_illegal});
    end
    release_rsp();
  endtask

  task automatic test_sub();
    int lat;
    issue(3'd3, 16'h0005, 16'h0005, lat);
    checks++;
    if (rsp_result !== 16'h0000) begin errors++; $display("FAIL sub_eq_result got %h want 0000", rsp_result); end
    checks++;
    if ({rsp_zero, rsp_carry, rsp_ovf, rsp_illegal} !== 4'b1100) begin
      errors++; $display("FAIL sub_eq_flags got z/c/o/i=%b want 1100", {rsp_zero, rsp_carry, rsp_ovf, rsp_illegal});
    end
    release_rsp();
    issue(3'd3, 16'h0000, 16'h0001, lat);
    checks++;
    if (rsp_result !== 16'hFFFF) begin errors++; $display("FAIL sub_borrow_result got %h want FFFF", rsp_result); end
    checks++;
    if ({rsp_zero, rsp_carry, rsp_ovf, rsp_illegal} !== 4'b0000) begin
      errors++; $display("FAIL sub_borrow_flags got z/c/o/i=%b want 0000", {rsp_zero, rsp_carry, rsp_ovf, rsp_illegal});
    end
    release_rsp();
  endtask

  task automatic test_logic();
    logic [2:0]       ops [3] = '{3'd0, 3'd1, 3'd4};
    logic [WIDTH-1:0] exp [3] = '{16'h3030, 16'hFCFC, 16'hCCCC};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 16'hF0F0, 16'h3C3C, lat);
      checks++;
      if (rsp_result !== exp[i]) begin
        errors++; $display("FAIL logic_result op=%0d got %h want %h", ops[i], rsp_result, exp[i]);
      end
      checks++;
      if ({rsp_zero, rsp_carry, rsp_ovf, rsp_illegal} !== 4'b0000) begin
        errors++; $display("FAIL logic_flags op=%0d got z/c/o/i=%b want 0000", ops[i],
          {rsp_zero, rsp_carry, rsp_ovf, rsp_illegal});
      end
      release_rsp();
    end
  endtask

  task automatic test_illegal();
    int lat;
    issue(3'd6, 16'h1234, 16'h5678, lat);
    // DONE is entered directly on the accepting edge.
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL illegal_latency got %0d want 0", lat); end
    checks++;
    if (rsp_result !== 16'h0000) begin errors++; $display("FAIL illegal_result got %h want 0000", rsp_result); end
    checks++;
    if ({rsp_zero, rsp_carry, rsp_ovf, rsp_illegal} !== 4'b0001) begin
      errors++; $display("FAIL illegal_flags got z/c/o/i=%b want 0001", {rsp_zero, rsp_carry, rsp_ovf, rsp_illegal});
    end
    release_rsp();
    issue(3'd2, 16'h0003, 16'h0004, lat);
    checks++;
    if ({rsp_result, rsp_illegal} !== {16'h0007, 1'b0}) begin
      errors++; $display("FAIL illegal_then_add got %h/%b want 0007/0", rsp_result, rsp_illegal);
    end
    release_rsp();
  endtask

  task automatic test_hold();
    int lat;
    issue(3'd2, 16'h1234, 16'h0001, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, 16'h1235}) begin
        errors++; $display("FAIL hold_stable cycle %0d got vld=%b rdy=%b res=%h want 1/0/1235",
          i, rsp_valid, req_ready, rsp_result);
      end
    end
    release_rsp();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_release got vld/rdy=%b want 01", {rsp_valid, req_ready});
    end
    issue(3'd4, 16'h00FF, 16'h0F0F, lat);
    checks++;
    if (rsp_result !== 16'h0FF0) begin errors++; $display("FAIL back_to_back got %h want 0FF0", rsp_result); end
    release_rsp();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd2; req_a = 16'h1111; req_b = 16'h2222;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (slice_op !== 3'd2) begin errors++; $display("FAIL midrun_running got slice_op=%0d want 2", slice_op); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rsp_valid, req_ready, slice_a, slice_b, slice_cin, slice_op} !== 8'b01000000) begin
      errors++; $display("FAIL midrun_reset got vld/rdy/slice=%b want 01000000",
        {rsp_valid, req_ready, slice_a, slice_b, slice_cin, slice_op});
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrun_no_rsp got rsp_valid seen=%b want 0", seen); end
    issue(3'd2, 16'h00FF, 16'h0001, lat);
    checks++;
    if ({rsp_result, rsp_zero, rsp_carry, rsp_ovf} !== {16'h0100, 3'b000}) begin
      errors++; $display("FAIL midrun_next_op got %h/%b want 0100/000", rsp_result, {rsp_zero, rsp_carry, rsp_ovf});
    end
    release_rsp();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_add();
    test_sub();
    test_logic();
    test_illegal();
    test_hold();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
